// File: rtl/user_counter_sched.sv
// user_counter_sched: round-robin scheduler sharing one user_simple_counter among NUM_REQ requesters.
// Define USER_COUNTER_SCHED_ABORT_EN to add per-requester cancel (abort_i) and the aborted_o qualifier.
module user_counter_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ-1:0][CNT_W-1:0]    req_len_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic [NUM_REQ-1:0]               done_o,
    output logic                             busy_o,
    output logic [$clog2(NUM_REQ)-1:0]       owner_o,
    output logic                             cnt_enable_o,
    output logic [CNT_W-1:0]                 cnt_end_val_o,
    input  logic                             cnt_done_i
`ifdef USER_COUNTER_SCHED_ABORT_EN
    ,
    input  logic [NUM_REQ-1:0]               abort_i,
    output logic                             aborted_o
`endif
);

    localparam int OW = $clog2(NUM_REQ);

    // state  | meaning
    // S_IDLE | arbitrating, ready offered to the round-robin winner
    // S_RUN  | counter enabled, waiting for cnt_done_i
    // S_DONE | one-cycle completion pulse to the owner, counter cleared
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    last_q;
    logic [CNT_W-1:0] len_q;

    logic             win_found;
    logic [OW-1:0]    win_idx;
    logic [OW-1:0]    idx_sel;
    int               idx_v;

    // First valid requester searching upward from last_q+1 with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_v     = 0;
        idx_sel   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_v = int'(last_q) + i;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end
            idx_sel = idx_v[OW-1:0];
            if (!win_found && req_valid_i[idx_sel]) begin
                win_found = 1'b1;
                win_idx   = idx_sel;
            end
        end
    end

`ifdef USER_COUNTER_SCHED_ABORT_EN
    logic aborted_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            last_q    <= OW'(NUM_REQ - 1);
            len_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        len_q   <= req_len_i[win_idx];
                        owner_q <= win_idx;
                        state_q <= (req_len_i[win_idx] == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort takes precedence over a simultaneous counter done.
                    if (abort_i[owner_q]) begin
                        state_q   <= S_DONE;
                        aborted_q <= 1'b1;
                    end else if (cnt_done_i) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_q    <= owner_q;
                    aborted_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign aborted_o = aborted_q & ~rst_i;
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_REQ - 1);
            len_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        len_q   <= req_len_i[win_idx];
                        owner_q <= win_idx;
                        state_q <= (req_len_i[win_idx] == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt_done_i) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_q  <= owner_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`endif

    // Outputs are forced quiet while reset is asserted so the counter clears in the same cycle.
    assign req_ready_o   = (state_q == S_IDLE && win_found && !rst_i) ? (NUM_REQ'(1) << win_idx) : '0;
    assign done_o        = (state_q == S_DONE && !rst_i) ? (NUM_REQ'(1) << owner_q) : '0;
    assign busy_o        = (state_q != S_IDLE) && !rst_i;
    assign cnt_enable_o  = (state_q == S_RUN) && !rst_i;
    assign cnt_end_val_o = rst_i ? '0 : len_q;
    assign owner_o       = owner_q;

endmodule

// File: doc/user_counter_sched.md
Name: user_counter_sched

Overview:
- Round-robin scheduler that shares one `user_simple_counter` instance between NUM_REQ requesters.
- Each requester asks for a delay of N clock cycles. The scheduler grants one request at a time and drives the counter's enable/end_val. It watches the counter's done and returns a one-cycle completion pulse to the owning requester.
- Sits in the user domain between peripheral logic and the shared counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 16, delay/counter width; must match the counter's end_val/count width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_len_i  in  NUM_REQ x CNT_W  per-requester delay length in cycles (packed array).
- req_ready_o  out  NUM_REQ  one-hot acceptance; a request is taken when valid & ready are both high.
- done_o  out  NUM_REQ  one-hot, 1-cycle completion pulse to the owner.
- busy_o  out  1  high whenever state is not IDLE.
- owner_o  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- cnt_enable_o  out  1  to counter `enable`.
- cnt_end_val_o  out  CNT_W  to counter `end_val`.
- cnt_done_i  in  1  from counter `done`.

Behaviour:
- Reset (clk_i edge with rst_i=1): state=IDLE, owner_o=0, len_q=0, rr pointer such that requester 0 has highest priority.
  - Outputs during reset: req_ready_o=0, done_o=0, busy_o=0, cnt_enable_o=0, cnt_end_val_o=0.
- Reset mid-operation: abandons the run immediately, with no done_o pulse; the counter clears because cnt_enable_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any req_valid_i is set, the round-robin winner w is the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready_o[w]=1 combinationally in this cycle; all other ready bits are 0.
  - At the edge: latch len_q=req_len_i[w] and owner=w.
  - Next state: DONE if len_q==0, else RUN.
  - With no valid request, stay in IDLE.
- RUN:
  - cnt_enable_o=1, cnt_end_val_o=len_q.
  - When cnt_done_i=1, go to DONE at the next edge. RUN therefore lasts exactly len_q cycles, because the counter starts from 0.
- DONE:
  - One cycle, with done_o[owner]=1 and cnt_enable_o=0, which clears the counter.
  - last_grant=owner; next state is IDLE.
- cnt_done_i is ignored outside RUN. The counter's done is combinational and may be high when end_val=1 and enable=0.
- cnt_end_val_o holds len_q in all states; len_q changes only on acceptance.
- Latency:
  - Accepted at cycle T with len≥1: done_o at cycle T+1+len.
  - Accepted at cycle T with len=0: done_o at cycle T+1.
  - Next acceptance earliest at T+2+len, so throughput is one job per len+2 cycles.
- req_valid_i may drop before ready without penalty; nothing is latched. req_len_i must be stable while valid is high.
- A requester may re-request in its own done cycle. It is seen in the following IDLE cycle and arbitrated fairly (it now has lowest priority).
- Full-range length: len=16'hFFFF gives a RUN of 65535 cycles. There is no wrap issue because len_q==0 never reaches RUN.

Optional Feature:
- Macro: USER_COUNTER_SCHED_ABORT_EN.
- When defined, two extra ports are added:
  - abort_i  in  NUM_REQ: per-requester cancel.
  - aborted_o  out  1: qualifies done_o; reset 0.
- Abort behaviour with the macro defined:
  - In RUN, abort_i[owner]=1 forces DONE at the next edge, regardless of cnt_done_i. aborted_o=1 alongside done_o[owner].
  - abort_i for non-owners, or abort_i outside RUN, is ignored.
  - If abort_i[owner] and cnt_done_i are high in the same cycle, the abort wins (aborted_o=1).
- When undefined: neither port exists and runs always complete fully.

Test Plan:
- Single request, len=5:
  - req_valid_i=4'b0001 at cycle 10.
  - Required: req_ready_o[0]=1 at cycle 10; cnt_enable_o high for cycles 11–15; done_o=4'b0001 at cycle 16 only; busy_o=0 at cycle 17.
- Zero length:
  - req_valid_i[2] with len=0.
  - Required: ready at T, done_o[2] at T+1, cnt_enable_o never high.
- Round-robin fairness:
  - All four valid continuously, all len=2.
  - Required: grants in order 0,1,2,3,0; one done every 4 cycles; owner_o follows the same order.
- Reset mid-run:
  - len=100; assert rst_i for one cycle at RUN cycle 40.
  - Required: no done_o pulse; state IDLE; cnt_enable_o=0 the following cycle; the next grant goes to requester 0.
- Max length and stray done:
  - len=16'hFFFF on requester 1: done_o[1] exactly 65536 cycles after acceptance.
  - Separately, with cnt_done_i forced high in IDLE: no spurious done_o.
- Abort (USER_COUNTER_SCHED_ABORT_EN):
  - len=50; abort_i[owner] at RUN cycle 7 → done_o[owner] and aborted_o=1 at the next cycle.
  - abort_i on a non-owner → ignored.
